pc_unit: RTL and testbench

Program-counter and branch-resolution stage, downstream of the ALU in the single-cycle core. It consumes the current opcode, the ALU result and the ALU flags. It holds the architectural flag register (co, lt, z), resolves the kBE/kBL/kBG/kBA branches, and sequences the PC through a start/run/done lifecycle. It also inserts the one-cycle stall that the synchronous data memory needs on kLD.

---
 rtl/pc_unit_pkg.sv | 36 +++
 rtl/pc_unit_if.sv | 29 ++
 rtl/pc_unit_flag_reg.sv | 32 +++
 rtl/pc_unit.sv | 101 ++++++++++
 tb/tb_pc_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the core: op encodings, PC-stage FSM states and flag bit order.
package pc_unit_pkg;

  localparam logic [4:0] kADD = 5'd0;
  localparam logic [4:0] kSUB = 5'd1;
  localparam logic [4:0] kAND = 5'd2;
  localparam logic [4:0] kOR  = 5'd3;
  localparam logic [4:0] kCMP = 5'd4;
  localparam logic [4:0] kLD  = 5'd5;
  localparam logic [4:0] kST  = 5'd6;
  localparam logic [4:0] kBE  = 5'd7;
  localparam logic [4:0] kBL  = 5'd8;
  localparam logic [4:0] kBG  = 5'd9;
  localparam logic [4:0] kBA  = 5'd10;

  typedef enum logic [1:0] {IDLE, RUN, LDWAIT, DONE} pc_state_t;

  localparam int FLAG_CO = 2;
  localparam int FLAG_LT = 1;
  localparam int FLAG_Z  = 0;

  // Branch condition on the registered flags; non-branch ops never take.
  function automatic logic branch_cond(input logic [4:0] op, input logic [2:0] flags);
    logic r_c;
    r_c = 1'b0;
    case (op)
      kBE:     r_c = flags[FLAG_Z];
      kBL:     r_c = flags[FLAG_LT];
      kBG:     r_c = !flags[FLAG_Z] && !flags[FLAG_LT];
      kBA:     r_c = 1'b1;
      default: r_c = 1'b0;
    endcase
    return r_c;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Decoder/ALU-facing bundle of the PC stage; master = core side, slave = pc_unit.
interface pc_unit_if #(parameter int PC_W = 10);
  import pc_unit_pkg::*;

  logic            start;
  logic            halt;
  logic [4:0]      op;
  logic [7:0]      alu_rslt;
  logic            alu_co;
  logic            alu_lt;
  logic            alu_z;
  logic [PC_W-1:0] pc;
  logic            taken;
  logic            stall;
  logic            done;
  logic [2:0]      flags;
  pc_state_t       state;

  modport master (
    output start, halt, op, alu_rslt, alu_co, alu_lt, alu_z,
    input  pc, taken, stall, done, flags, state
  );

  modport slave (
    input  start, halt, op, alu_rslt, alu_co, alu_lt, alu_z,
    output pc, taken, stall, done, flags, state
  );

endinterface

// File: rtl/pc_unit_flag_reg.sv
// Architectural flag register {co, lt, z}; CMP loads lt/z, ADD loads co.
module flag_reg
  import pc_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [4:0] i_op,
  input  logic       i_alu_co,
  input  logic       i_alu_lt,
  input  logic       i_alu_z,
  output logic [2:0] o_flags
);

  logic [2:0] r_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 3'b000;
    end else if (i_en) begin
      if (i_op == kCMP) begin
        r_flags[FLAG_LT] <= i_alu_lt;
        r_flags[FLAG_Z]  <= i_alu_z;
      end else if (i_op == kADD) begin
        r_flags[FLAG_CO] <= i_alu_co;
      end
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/pc_unit.sv
// PC sequencing and branch resolution with a one-cycle load stall.
// Define ABS_TARGET_EN for absolute (zero-extended) branch targets; default is PC-relative.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int PC_W = 10
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);

  pc_state_t       r_state;
  pc_state_t       w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;
  logic [2:0]      w_flags;
  logic            w_taken;
  logic            w_flag_en;

  assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

`ifdef ABS_TARGET_EN
  assign w_target = {{(PC_W-8){1'b0}}, bus.alu_rslt};
`else
  // Adder width is PC_W, so the target wraps modulo 2^PC_W in both directions.
  assign w_target = r_pc + {{(PC_W-8){bus.alu_rslt[7]}}, bus.alu_rslt};
`endif

  assign w_taken   = (r_state == RUN) && branch_cond(bus.op, w_flags);
  assign w_flag_en = (r_state == RUN) && !bus.halt;

  flag_reg u_flag_reg (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_flag_en),
    .i_op     (bus.op),
    .i_alu_co (bus.alu_co),
    .i_alu_lt (bus.alu_lt),
    .i_alu_z  (bus.alu_z),
    .o_flags  (w_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = '0;
        end
      end
      RUN: begin
        if (bus.halt) begin
          w_state_nxt = DONE;
        end else if (bus.op == kLD) begin
          w_state_nxt = LDWAIT;
        end else if (w_taken) begin
          w_pc_nxt = w_target;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      LDWAIT: begin
        w_state_nxt = RUN;
        w_pc_nxt    = w_pc_inc;
      end
      DONE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  assign bus.pc    = r_pc;
  assign bus.taken = w_taken;
  assign bus.stall = (r_state == LDWAIT);
  assign bus.done  = (r_state == DONE);
  assign bus.flags = w_flags;
  assign bus.state = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations plus random traffic against a behavioural model.
module tb_pc_unit;
  import pc_unit_pkg::*;

  localparam int PC_W   = 10;
  localparam int PC_MOD = 1 << PC_W;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_unit_if #(.PC_W(PC_W)) bus();

  pc_unit #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [PC_W-1:0] exp_q[$];

  // behavioural model: mode 0=idle 1=run 2=ldwait 3=done
  int m_mode;
  int m_pc;
  bit m_co, m_lt, m_z;
  logic s_taken;

  function automatic bit m_taken(input logic [4:0] o);
    if (m_mode != 1) return 1'b0;
    if (o == kBA) return 1'b1;
    if (o == kBE) return m_z;
    if (o == kBL) return m_lt;
    if (o == kBG) return !m_z && !m_lt;
    return 1'b0;
  endfunction

  function automatic int m_target(input logic [7:0] r);
    int off;
`ifdef ABS_TARGET_EN
    off = int'(r);
    return off;
`else
    off = (r >= 8'd128) ? int'(r) - 256 : int'(r);
    return (m_pc + off + PC_MOD) % PC_MOD;
`endif
  endfunction

  task automatic model_step(input bit st, input bit hl, input logic [4:0] o,
                            input logic [7:0] r, input bit co, input bit lt, input bit z);
    bit tk;
    tk = m_taken(o);
    if (reset) begin
      m_mode = 0; m_pc = 0; m_co = 0; m_lt = 0; m_z = 0;
    end else begin
      case (m_mode)
        0: if (st) begin m_mode = 1; m_pc = 0; end
        1: begin
          if (hl) begin
            m_mode = 3;
          end else begin
            if (o == kCMP) begin m_lt = lt; m_z = z; end
            if (o == kADD) m_co = co;
            if (o == kLD) m_mode = 2;
            else if (tk) m_pc = m_target(r);
            else m_pc = (m_pc + 1) % PC_MOD;
          end
        end
        2: begin m_mode = 1; m_pc = (m_pc + 1) % PC_MOD; end
        default: if (st) begin m_mode = 1; m_pc = 0; end
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs, compare outputs, advance model
  task automatic cyc(input bit st, input bit hl, input logic [4:0] o,
                     input logic [7:0] r, input bit co, input bit lt, input bit z);
    bus.start = st; bus.halt = hl; bus.op = o; bus.alu_rslt = r;
    bus.alu_co = co; bus.alu_lt = lt; bus.alu_z = z;
    #1;
    chk("pc", int'(bus.pc), int'(exp_q.pop_front()));
    chk("taken", int'(bus.taken), int'(m_taken(o)));
    chk("stall", int'(bus.stall), int'(m_mode == 2));
    chk("done", int'(bus.done), int'(m_mode == 3));
    chk("flags", int'(bus.flags), int'({m_co, m_lt, m_z}));
    s_taken = bus.taken;
    @(posedge clk);
    model_step(st, hl, o, r, co, lt, z);
    exp_q.push_back(m_pc[PC_W-1:0]);
    @(negedge clk);
  endtask

  task automatic nop();
    cyc(1'b0, 1'b0, kSUB, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic jump(input int to);
    logic [7:0] r;
`ifdef ABS_TARGET_EN
    r = 8'(to);
`else
    r = 8'(to - m_pc);
`endif
    cyc(1'b0, 1'b0, kBA, r, 1'b0, 1'b0, 1'b0);
  endtask

  logic [4:0] rop;

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.halt = 0; bus.op = kSUB; bus.alu_rslt = 0;
    bus.alu_co = 0; bus.alu_lt = 0; bus.alu_z = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_mode = 0; m_pc = 0; m_co = 0; m_lt = 0; m_z = 0;
    exp_q.push_back('0);
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_flags", int'(bus.flags), 0);
    chk("rst_state", int'(bus.state), int'(IDLE));
    reset = 1'b0;

    // start, then sequential advance
    cyc(1'b1, 1'b0, kSUB, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("start_pc0", int'(bus.pc), 0);
    nop(); chk("seq_pc1", int'(bus.pc), 1);
    nop(); chk("seq_pc2", int'(bus.pc), 2);
    cyc(1'b0, 1'b0, kADD, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, kCMP, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("flags_111", int'(bus.flags), 7);
    jump(37);
    chk("jump_pc37", int'(bus.pc), 37);

    // reset mid-RUN
    reset = 1'b1;
    nop();
    reset = 1'b0;
    chk("rstrun_pc", int'(bus.pc), 0);
    chk("rstrun_flags", int'(bus.flags), 0);
    chk("rstrun_state", int'(bus.state), int'(IDLE));
    chk("rstrun_done", int'(bus.done), 0);

    // compare then taken branch
    cyc(1'b1, 1'b0, kSUB, 8'h00, 1'b0, 1'b0, 1'b0);
    jump(10);
    cyc(1'b0, 1'b0, kCMP, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("cmp_flags", int'(bus.flags), 1);
    chk("cmp_pc11", int'(bus.pc), 11);
    cyc(1'b0, 1'b0, kBE, 8'hFB, 1'b0, 1'b0, 1'b0);
    chk("be_taken", int'(s_taken), 1);
`ifdef ABS_TARGET_EN
    chk("be_pc", int'(bus.pc), 251);
`else
    chk("be_pc", int'(bus.pc), 6);
`endif

    // not-taken BG, taken BL with z=0 lt=1
    cyc(1'b0, 1'b0, kCMP, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("flags_010", int'(bus.flags), 2);
    cyc(1'b0, 1'b0, kBG, 8'h03, 1'b0, 1'b0, 1'b0);
    chk("bg_not_taken", int'(s_taken), 0);
    cyc(1'b0, 1'b0, kBL, 8'h03, 1'b0, 1'b0, 1'b0);
    chk("bl_taken", int'(s_taken), 1);

    // load stall; the op presented during LDWAIT must be ignored
    jump(20);
    cyc(1'b0, 1'b0, kLD, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("ld_stall", int'(bus.stall), 1);
    chk("ld_pc_hold", int'(bus.pc), 20);
    cyc(1'b0, 1'b0, kCMP, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("ld_stall_off", int'(bus.stall), 0);
    chk("ld_pc21", int'(bus.pc), 21);
    chk("ld_flags", int'(bus.flags), 2);

    // wrap / absolute target
`ifdef ABS_TARGET_EN
    cyc(1'b0, 1'b0, kBA, 8'hC8, 1'b0, 1'b0, 1'b0);
    chk("abs_pc200", int'(bus.pc), 200);
`else
    jump(0);
    cyc(1'b0, 1'b0, kBA, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("wrap_back", int'(bus.pc), 1023);
    nop();
    chk("wrap_fwd", int'(bus.pc), 0);
`endif

    // halt and restart
    jump(55);
    cyc(1'b0, 1'b1, kSUB, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("halt_done", int'(bus.done), 1);
    chk("halt_pc", int'(bus.pc), 55);
    cyc(1'b0, 1'b0, kCMP, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("done_pc", int'(bus.pc), 55);
    chk("done_flags", int'(bus.flags), 2);
    cyc(1'b1, 1'b0, kSUB, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("restart_pc", int'(bus.pc), 0);
    chk("restart_done", int'(bus.done), 0);
    chk("restart_flags", int'(bus.flags), 2);
    cyc(1'b1, 1'b0, kSUB, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("run_start_ign", int'(bus.pc), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      rop = 5'($urandom_range(0, 10));
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 39) == 0), rop,
          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (m_mode == 0 && $urandom_range(0, 3) == 0) begin
        reset = 1'b0;
        cyc(1'b1, 1'b0, kSUB, 8'h00, 1'b0, 1'b0, 1'b0);
      end
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
